eth_rx_dispatch: RTL and testbench
==================================

// Module: eth_rx_dispatch
// PURPOSE
// - Receive-side stage between the Ethernet MAC RX Avalon-ST output and the NIC RX inputs.
// - Steers each whole packet from the single MAC RX stream to one of NUM_NICS NICs.
// - Steering key: least-significant byte of the destination MAC address.
// - Drops packets that are unaddressable, disabled or malformed, and keeps per-destination packet counters.
// PARAMETERS
// NUM_NICS     3    number of NIC RX ports (1..8)
// DATA_WIDTH   256  Avalon-ST data width; byte 0 = data[DATA_WIDTH-1 -: 8]
// EMPTY_WIDTH  5    width of the empty field (log2 of DATA_WIDTH/8)
// ERROR_WIDTH  6    width of the error field
// PORTS
// clk             in   1                   single clock; MAC RX domain
// reset_n         in   1                   asynchronous, active-low reset
// cfg_enable      in   1                   1 = steer packets; 0 = drop new packets
// rx_data_in      in   DATA_WIDTH          MAC RX data
// rx_valid_in     in   1                   MAC RX beat valid
// rx_sop_in       in   1                   start of packet
// rx_eop_in       in   1                   end of packet
// rx_empty_in     in   EMPTY_WIDTH         empty bytes on eop beat
// rx_error_in     in   ERROR_WIDTH         MAC error flags
// rx_ready_out    out  1                   ready to the MAC
// nic_data_out    out  DATA_WIDTH          shared data bus to all NICs
// nic_sop_out     out  1                   shared start of packet
// nic_eop_out     out  1                   shared end of packet
// nic_empty_out   out  EMPTY_WIDTH         shared empty field
// nic_error_out   out  ERROR_WIDTH         shared error field
// nic_valid_out   out  NUM_NICS            one-hot beat valid, bit i = NIC i
// nic_ready_in    in   NUM_NICS            per-NIC ready
// pkt_cnt_out     out  NUM_NICS*32         forwarded packets; NIC i at [32*i +: 32]
// drop_cnt_out    out  32                  packets dropped (bad key, disabled or orphan)
// malformed_cnt_out out 32                 packets cut short by a sop arriving mid-packet
// BEHAVIOUR
// Reset values
// - All outputs 0; FSM state = IDLE; output register empty; all counters 0.
// - Reset asserted mid-packet aborts it; no partial beat survives.
// Datapath and handshake
// - One output holding register: valid, dest, data, sop, eop, empty, error.
// - nic_valid_out[i] = out_valid && (dest == i).
// - A beat is accepted when rx_valid_in && rx_ready_out.
// - rx_ready_out = !out_valid || nic_ready_in[dest], combinational. In DROP it also includes the incoming beat.
// - Latency: a forwarded beat appears on the NIC outputs 1 cycle after it is accepted.
// - The output register loads on the same cycle it drains, giving full throughput.
// - The output register holds steady while the selected NIC deasserts ready; no beat is lost or duplicated.
// Key and decision
// - key = data[DATA_WIDTH-41 -: 8], i.e. byte 5, sampled on the sop beat.
// - Forward if cfg_enable && key < NUM_NICS; dest = key[2:0]. Otherwise drop.
// - The decision is made once per packet. Changing cfg_enable mid-packet has no effect until the next sop.
// FSM (updated on accepted beats only)
// - IDLE
//   - sop beat, forward -> load beat; go to FWD. If the beat also has eop: pkt_cnt[dest]++ and stay in IDLE.
//   - sop beat, drop -> discard; go to DROP. If the beat also has eop: drop_cnt++ and stay in IDLE.
//   - non-sop beat (orphan) -> discard; go to DROP. If the beat also has eop: drop_cnt++ and stay in IDLE.
// - FWD
//   - non-sop beat -> load it.
//   - eop beat -> pkt_cnt[dest]++; go to IDLE.
// - FWD, sop beat arrives
//   - Load it with eop forced to 1, empty = 0 and error[0] forced to 1.
//   - malformed_cnt++; go to DROP to drop the rest of the new packet.
//   - If that beat also carries eop: return to IDLE instead.
// - DROP
//   - Discard every beat.
//   - eop beat -> drop_cnt++; go to IDLE.
//   - A sop beat in DROP restarts the drop without incrementing any counter.
// Counters
// - All counters are 32-bit and wrap to 0 after 0xFFFFFFFF.
// - Counters are updated on the accept cycle and are visible on the next cycle.
// TESTING
// - 3-beat packet, key = 0x01, all NICs ready -> 3 beats on nic_valid_out = 3'b010 in order, 1-cycle latency; pkt_cnt[1] = 1.
// - 2-beat packet with key = 0x07 (NUM_NICS = 3) -> nic_valid_out stays 0; drop_cnt = 1; rx_ready_out = 1 throughout.
// - Packet to NIC 2 with nic_ready_in[2] low for 4 cycles mid-packet -> output held stable; rx_ready_out low during the stall; no loss.
// - sop on beat 2 of an open packet to NIC 0 -> that beat emitted with eop = 1 and error[0] = 1; malformed_cnt = 1; next packet dropped to its eop.
// - cfg_enable falls mid-packet -> current packet completes to its NIC; next packet dropped; drop_cnt = 1.
// - reset_n low for 1 cycle mid-packet -> all outputs 0 immediately; following clean packet forwarded normally.

Source files
------------

// File: rtl/eth_rx_dispatch.sv
// Receive-side packet steering from the single MAC RX Avalon-ST stream to one of
// NUM_NICS NIC ports, keyed on the low byte of the destination MAC, with drop counters.
module eth_rx_dispatch #(
    parameter int NUM_NICS    = 3,
    parameter int DATA_WIDTH  = 256,
    parameter int EMPTY_WIDTH = 5,
    parameter int ERROR_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_enable,
    input  logic [DATA_WIDTH-1:0]    rx_data_in,
    input  logic                     rx_valid_in,
    input  logic                     rx_sop_in,
    input  logic                     rx_eop_in,
    input  logic [EMPTY_WIDTH-1:0]   rx_empty_in,
    input  logic [ERROR_WIDTH-1:0]   rx_error_in,
    output logic                     rx_ready_out,
    output logic [DATA_WIDTH-1:0]    nic_data_out,
    output logic                     nic_sop_out,
    output logic                     nic_eop_out,
    output logic [EMPTY_WIDTH-1:0]   nic_empty_out,
    output logic [ERROR_WIDTH-1:0]   nic_error_out,
    output logic [NUM_NICS-1:0]      nic_valid_out,
    input  logic [NUM_NICS-1:0]      nic_ready_in,
    output logic [NUM_NICS*32-1:0]   pkt_cnt_out,
    output logic [31:0]              drop_cnt_out,
    output logic [31:0]              malformed_cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [31:0] cnt_inc(input logic [31:0] c);
        return c + 32'd1;
    endfunction

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic                     run_r;
    logic                     out_valid_r;
    logic [2:0]               out_dest_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic                     out_sop_r;
    logic                     out_eop_r;
    logic [EMPTY_WIDTH-1:0]   out_empty_r;
    logic [ERROR_WIDTH-1:0]   out_error_r;
    logic [2:0]               fwd_dest_r;
    logic [2:0]               fwd_dest_nxt_s;
    logic [31:0]              pkt_cnt_r [NUM_NICS];
    logic [31:0]              drop_cnt_r;
    logic [31:0]              mal_cnt_r;

    logic [7:0]               ready_pad_s;
    logic                     drain_s;
    logic                     rx_ready_s;
    logic                     accept_s;
    logic [7:0]               key_s;
    logic                     key_ok_s;
    logic                     load_s;
    logic [2:0]               load_dest_s;
    logic                     trunc_s;
    logic                     pkt_inc_s;
    logic [2:0]               pkt_dest_s;
    logic                     drop_inc_s;
    logic                     mal_inc_s;

    // Widen per-NIC ready to 8 bits so a 3-bit destination always indexes safely.
    always_comb begin
        ready_pad_s = 8'h00;
        for (int i = 0; i < NUM_NICS; i++) begin
            ready_pad_s[i] = nic_ready_in[i];
        end
    end

    // run_r keeps ready low while reset is held and for the first cycle after.
    assign drain_s    = out_valid_r && ready_pad_s[out_dest_r];
    assign rx_ready_s = run_r && (!out_valid_r || ready_pad_s[out_dest_r]);
    assign accept_s   = rx_valid_in && rx_ready_s;
    assign key_s      = rx_data_in[DATA_WIDTH-41 -: 8];
    assign key_ok_s   = cfg_enable && ({1'b0, key_s} < 9'(NUM_NICS));

    // Next-state, load and counter-increment decisions on accepted beats.
    always_comb begin
        state_nxt_s    = state_r;
        fwd_dest_nxt_s = fwd_dest_r;
        load_s         = 1'b0;
        load_dest_s    = fwd_dest_r;
        trunc_s        = 1'b0;
        pkt_inc_s      = 1'b0;
        pkt_dest_s     = fwd_dest_r;
        drop_inc_s     = 1'b0;
        mal_inc_s      = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_sop_in && key_ok_s) begin
                        load_s         = 1'b1;
                        load_dest_s    = key_s[2:0];
                        fwd_dest_nxt_s = key_s[2:0];
                        if (rx_eop_in) begin
                            pkt_inc_s   = 1'b1;
                            pkt_dest_s  = key_s[2:0];
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_FWD;
                        end
                    end else if (rx_eop_in) begin
                        drop_inc_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                ST_FWD: begin
                    load_s = 1'b1;
                    if (rx_sop_in) begin
                        // New packet barged in: close the old one on its NIC, drop the rest.
                        trunc_s     = 1'b1;
                        mal_inc_s   = 1'b1;
                        state_nxt_s = rx_eop_in ? ST_IDLE : ST_DROP;
                    end else if (rx_eop_in) begin
                        pkt_inc_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FWD;
                    end
                end
                ST_DROP: begin
                    if (rx_eop_in) begin
                        drop_inc_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and per-packet destination.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            fwd_dest_r <= 3'd0;
            run_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fwd_dest_r <= fwd_dest_nxt_s;
            run_r      <= 1'b1;
        end
    end

    // Output holding register: loads on accept, empties when the selected NIC takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_dest_r  <= 3'd0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_empty_r <= {EMPTY_WIDTH{1'b0}};
            out_error_r <= {ERROR_WIDTH{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_dest_r  <= load_dest_s;
            out_data_r  <= rx_data_in;
            out_sop_r   <= rx_sop_in;
            out_eop_r   <= rx_eop_in | trunc_s;
            out_empty_r <= trunc_s ? {EMPTY_WIDTH{1'b0}} : rx_empty_in;
            out_error_r <= rx_error_in | ERROR_WIDTH'(trunc_s);
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Packet counters, all wrapping at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NICS; i++) begin
                pkt_cnt_r[i] <= 32'd0;
            end
            drop_cnt_r <= 32'd0;
            mal_cnt_r  <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_NICS; i++) begin
                if (pkt_inc_s && (pkt_dest_s == 3'(i))) begin
                    pkt_cnt_r[i] <= cnt_inc(pkt_cnt_r[i]);
                end
            end
            if (drop_inc_s) begin
                drop_cnt_r <= cnt_inc(drop_cnt_r);
            end
            if (mal_inc_s) begin
                mal_cnt_r <= cnt_inc(mal_cnt_r);
            end
        end
    end

    // One-hot NIC valid decoded from the holding register.
    always_comb begin
        nic_valid_out = {NUM_NICS{1'b0}};
        for (int i = 0; i < NUM_NICS; i++) begin
            nic_valid_out[i] = out_valid_r && (out_dest_r == 3'(i));
        end
    end

    for (genvar g = 0; g < NUM_NICS; g++) begin : g_cnt
        assign pkt_cnt_out[32*g +: 32] = pkt_cnt_r[g];
    end

    assign rx_ready_out      = rx_ready_s;
    assign nic_data_out      = out_data_r;
    assign nic_sop_out       = out_sop_r;
    assign nic_eop_out       = out_eop_r;
    assign nic_empty_out     = out_empty_r;
    assign nic_error_out     = out_error_r;
    assign drop_cnt_out      = drop_cnt_r;
    assign malformed_cnt_out = mal_cnt_r;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed bench for eth_rx_dispatch: forwarding, drop, stall, malformed,
// enable change and mid-packet reset, each checked with immediate assertions.
module tb_eth_rx_dispatch;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cfg_enable;
    logic [255:0] rx_data_in;
    logic         rx_valid_in;
    logic         rx_sop_in;
    logic         rx_eop_in;
    logic [4:0]   rx_empty_in;
    logic [5:0]   rx_error_in;
    logic         rx_ready_out;
    logic [255:0] nic_data_out;
    logic         nic_sop_out;
    logic         nic_eop_out;
    logic [4:0]   nic_empty_out;
    logic [5:0]   nic_error_out;
    logic [2:0]   nic_valid_out;
    logic [2:0]   nic_ready_in;
    logic [95:0]  pkt_cnt_out;
    logic [31:0]  drop_cnt_out;
    logic [31:0]  malformed_cnt_out;

    int n_checks;
    int n_fail;
    logic [255:0] d0, d1, d2, d3;

    eth_rx_dispatch dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg_enable        (cfg_enable),
        .rx_data_in        (rx_data_in),
        .rx_valid_in       (rx_valid_in),
        .rx_sop_in         (rx_sop_in),
        .rx_eop_in         (rx_eop_in),
        .rx_empty_in       (rx_empty_in),
        .rx_error_in       (rx_error_in),
        .rx_ready_out      (rx_ready_out),
        .nic_data_out      (nic_data_out),
        .nic_sop_out       (nic_sop_out),
        .nic_eop_out       (nic_eop_out),
        .nic_empty_out     (nic_empty_out),
        .nic_error_out     (nic_error_out),
        .nic_valid_out     (nic_valid_out),
        .nic_ready_in      (nic_ready_in),
        .pkt_cnt_out       (pkt_cnt_out),
        .drop_cnt_out      (drop_cnt_out),
        .malformed_cnt_out (malformed_cnt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [7:0] key, input logic [31:0] tag);
        logic [255:0] d;
        d = {8{tag}};
        d[215:208] = key;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [255:0] d, input logic s, input logic e,
                         input logic [4:0] emp, input logic [5:0] err);
        rx_data_in  = d;
        rx_valid_in = 1'b1;
        rx_sop_in   = s;
        rx_eop_in   = e;
        rx_empty_in = emp;
        rx_error_in = err;
    endtask

    task automatic idle_in();
        rx_valid_in = 1'b0;
        rx_sop_in   = 1'b0;
        rx_eop_in   = 1'b0;
        rx_data_in  = 256'd0;
        rx_empty_in = 5'd0;
        rx_error_in = 6'd0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        cfg_enable   = 1'b1;
        nic_ready_in = 3'b111;
        idle_in();
        step();
        step();

        // reset state
        chk("rst_ready", 256'(rx_ready_out), 256'(1'b0));
        chk("rst_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("rst_data", nic_data_out, 256'd0);
        chk("rst_pkt", 256'(pkt_cnt_out), 256'd0);
        chk("rst_drop", 256'(drop_cnt_out), 256'd0);
        chk("rst_mal", 256'(malformed_cnt_out), 256'd0);
        reset_n = 1'b1;
        step();
        chk("ready_after_rst", 256'(rx_ready_out), 256'(1'b1));

        // 3-beat packet to NIC 1
        d0 = mk(8'h01, 32'h1000_0000);
        d1 = mk(8'h00, 32'h1000_0001);
        d2 = mk(8'h00, 32'h1000_0002);
        drive(d0, 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t1_valid0", 256'(nic_valid_out), 256'(3'b010));
        chk("t1_data0", nic_data_out, d0);
        chk("t1_sop0", 256'(nic_sop_out), 256'(1'b1));
        drive(d1, 1'b0, 1'b0, 5'd0, 6'd0);
        step();
        chk("t1_valid1", 256'(nic_valid_out), 256'(3'b010));
        chk("t1_data1", nic_data_out, d1);
        chk("t1_sop1", 256'(nic_sop_out), 256'(1'b0));
        drive(d2, 1'b0, 1'b1, 5'd3, 6'd0);
        step();
        chk("t1_data2", nic_data_out, d2);
        chk("t1_eop2", 256'(nic_eop_out), 256'(1'b1));
        chk("t1_empty2", 256'(nic_empty_out), 256'(5'd3));
        chk("t1_pkt1", 256'(pkt_cnt_out[63:32]), 256'(32'd1));
        idle_in();
        step();
        chk("t1_drained", 256'(nic_valid_out), 256'(3'b000));

        // key 7 is out of range -> dropped
        drive(mk(8'h07, 32'h2000_0000), 1'b1, 1'b0, 5'd0, 6'd0);
        #1;
        chk("t2_ready0", 256'(rx_ready_out), 256'(1'b1));
        step();
        chk("t2_valid0", 256'(nic_valid_out), 256'(3'b000));
        chk("t2_ready1", 256'(rx_ready_out), 256'(1'b1));
        drive(mk(8'h00, 32'h2000_0001), 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("t2_valid1", 256'(nic_valid_out), 256'(3'b000));
        chk("t2_drop", 256'(drop_cnt_out), 256'(32'd1));
        idle_in();
        step();

        // NIC 2 stalls for 4 cycles mid-packet
        d0 = mk(8'h02, 32'h3000_0000);
        d1 = mk(8'h00, 32'h3000_0001);
        d2 = mk(8'h00, 32'h3000_0002);
        drive(d0, 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t3_valid0", 256'(nic_valid_out), 256'(3'b100));
        chk("t3_data0", nic_data_out, d0);
        nic_ready_in = 3'b011;
        drive(d1, 1'b0, 1'b0, 5'd0, 6'd0);
        #1;
        chk("t3_stall_ready", 256'(rx_ready_out), 256'(1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_valid", 256'(nic_valid_out), 256'(3'b100));
            chk("t3_hold_data", nic_data_out, d0);
            chk("t3_hold_ready", 256'(rx_ready_out), 256'(1'b0));
        end
        nic_ready_in = 3'b111;
        #1;
        chk("t3_resume_ready", 256'(rx_ready_out), 256'(1'b1));
        step();
        chk("t3_data1", nic_data_out, d1);
        chk("t3_valid1", 256'(nic_valid_out), 256'(3'b100));
        drive(d2, 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("t3_data2", nic_data_out, d2);
        chk("t3_eop2", 256'(nic_eop_out), 256'(1'b1));
        chk("t3_pkt2", 256'(pkt_cnt_out[95:64]), 256'(32'd1));
        idle_in();
        step();

        // sop arrives on beat 2 of a packet to NIC 0
        d0 = mk(8'h00, 32'h4000_0000);
        d1 = mk(8'h00, 32'h4000_0001);
        d2 = mk(8'h01, 32'h4000_0002);
        d3 = mk(8'h00, 32'h4000_0003);
        drive(d0, 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t4_valid0", 256'(nic_valid_out), 256'(3'b001));
        drive(d1, 1'b0, 1'b0, 5'd0, 6'd0);
        step();
        chk("t4_data1", nic_data_out, d1);
        drive(d2, 1'b1, 1'b0, 5'd7, 6'b000010);
        step();
        chk("t4_trunc_valid", 256'(nic_valid_out), 256'(3'b001));
        chk("t4_trunc_data", nic_data_out, d2);
        chk("t4_trunc_eop", 256'(nic_eop_out), 256'(1'b1));
        chk("t4_trunc_empty", 256'(nic_empty_out), 256'(5'd0));
        chk("t4_trunc_error", 256'(nic_error_out), 256'(6'b000011));
        chk("t4_mal", 256'(malformed_cnt_out), 256'(32'd1));
        chk("t4_pkt0", 256'(pkt_cnt_out[31:0]), 256'(32'd0));
        drive(d3, 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("t4_drop_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("t4_drop", 256'(drop_cnt_out), 256'(32'd2));
        idle_in();
        step();

        // cfg_enable falls mid-packet
        d0 = mk(8'h00, 32'h5000_0000);
        d1 = mk(8'h00, 32'h5000_0001);
        drive(d0, 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t5_valid0", 256'(nic_valid_out), 256'(3'b001));
        cfg_enable = 1'b0;
        drive(d1, 1'b0, 1'b1, 5'd2, 6'd0);
        step();
        chk("t5_valid1", 256'(nic_valid_out), 256'(3'b001));
        chk("t5_data1", nic_data_out, d1);
        chk("t5_pkt0", 256'(pkt_cnt_out[31:0]), 256'(32'd1));
        drive(mk(8'h00, 32'h5000_0002), 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t5_next_valid", 256'(nic_valid_out), 256'(3'b000));
        drive(mk(8'h00, 32'h5000_0003), 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("t5_drop", 256'(drop_cnt_out), 256'(32'd3));
        cfg_enable = 1'b1;
        idle_in();
        step();

        // single-beat packets at the key boundary, and an orphan beat
        d0 = mk(8'h02, 32'h6000_0000);
        drive(d0, 1'b1, 1'b1, 5'd0, 6'd0);
        step();
        chk("b_key2_valid", 256'(nic_valid_out), 256'(3'b100));
        chk("b_key2_pkt", 256'(pkt_cnt_out[95:64]), 256'(32'd2));
        drive(mk(8'h03, 32'h6000_0001), 1'b1, 1'b1, 5'd0, 6'd0);
        step();
        chk("b_key3_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("b_key3_drop", 256'(drop_cnt_out), 256'(32'd4));
        drive(mk(8'h00, 32'h6000_0002), 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("b_orphan_drop", 256'(drop_cnt_out), 256'(32'd5));
        chk("b_orphan_mal", 256'(malformed_cnt_out), 256'(32'd1));
        idle_in();
        step();

        // reset asserted mid-packet
        drive(mk(8'h01, 32'h7000_0000), 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t6_valid0", 256'(nic_valid_out), 256'(3'b010));
        reset_n = 1'b0;
        idle_in();
        #1;
        chk("t6_rst_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("t6_rst_data", nic_data_out, 256'd0);
        chk("t6_rst_ready", 256'(rx_ready_out), 256'(1'b0));
        chk("t6_rst_pkt", 256'(pkt_cnt_out), 256'd0);
        chk("t6_rst_drop", 256'(drop_cnt_out), 256'd0);
        step();
        reset_n = 1'b1;
        step();
        d0 = mk(8'h01, 32'h7100_0000);
        d1 = mk(8'h00, 32'h7100_0001);
        drive(d0, 1'b1, 1'b0, 5'd0, 6'd0);
        step();
        chk("t6_clean_valid", 256'(nic_valid_out), 256'(3'b010));
        chk("t6_clean_data", nic_data_out, d0);
        drive(d1, 1'b0, 1'b1, 5'd0, 6'd0);
        step();
        chk("t6_clean_eop", 256'(nic_eop_out), 256'(1'b1));
        chk("t6_clean_pkt1", 256'(pkt_cnt_out[63:32]), 256'(32'd1));
        idle_in();
        step();
        chk("t6_drained", 256'(nic_valid_out), 256'(3'b000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
